// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the fetch-control block.
//   - state_e      : fetch FSM state encoding (BOOT, FETCH, STALL, DRAIN)
//   - PC_SEL_*     : PC mux select values driven on pc_sel
// ---------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam logic PC_SEL_INC    = 1'b0;  // next PC = PC + 4
  localparam logic PC_SEL_TARGET = 1'b1;  // next PC = pc_target

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   W-bit up counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clock  in   single clock, posedge
//     reset  in   asynchronous active-high clear
//     inc    in   add one this cycle (ignored once saturated)
//     count  out  current count
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_control.sv
// ---------------------------------------------------------------------------
// fetch_control
//   Instruction-fetch sequencer: drives the PC mux / load enable, the
//   instruction-memory request and the IF/ID register controls, handling
//   memory waits, load-use stalls and taken-branch redirects (including a
//   redirect that arrives while a fetch is still outstanding).
//   Ports:
//     clock, reset        single clock; asynchronous active-high reset
//     branch_taken        redirect request from execute
//     pc_branch   [63:0]  redirect target (valid with branch_taken)
//     hazard_stall        load-use stall request
//     imem_ack            instruction memory returned data this cycle
//     imem_req            fetch request to instruction memory
//     pc_write            PC register load enable
//     pc_sel              PC mux select (PC_SEL_INC / PC_SEL_TARGET)
//     pc_target   [63:0]  redirect address; zero when pc_sel selects PC+4
//     ifid_wren           IF/ID write enable
//     ifid_flush          IF/ID bubble insert
//     stall_count [CNT_W] saturating count of cycles without an IF/ID write
// ---------------------------------------------------------------------------
module fetch_control
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          CNT_W    = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             branch_taken,
  input  logic [63:0]      pc_branch,
  input  logic             hazard_stall,
  input  logic             imem_ack,
  output logic             imem_req,
  output logic             pc_write,
  output logic             pc_sel,
  output logic [63:0]      pc_target,
  output logic             ifid_wren,
  output logic             ifid_flush,
  output logic [CNT_W-1:0] stall_count
);

  state_e      state_q, state_d;
  logic [63:0] pending_q, pending_d;
  logic [63:0] target_c;

  // NOTE: every signal written here gets a default first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    imem_req   = 1'b0;
    pc_write   = 1'b0;
    pc_sel     = PC_SEL_INC;
    target_c   = '0;
    ifid_wren  = 1'b0;
    ifid_flush = 1'b0;

    case (state_q)
      BOOT: begin
        pc_write = 1'b1;
        pc_sel   = PC_SEL_TARGET;
        target_c = RESET_PC;
        state_d  = FETCH;
      end

      FETCH: begin
        imem_req = 1'b1;
        if (branch_taken) begin
          ifid_flush = 1'b1;
          if (imem_ack) begin
            pc_write = 1'b1;
            pc_sel   = PC_SEL_TARGET;
            target_c = pc_branch;
          end else begin
            // Fetch still in flight: remember where to go once it returns.
            pending_d = pc_branch;
            state_d   = DRAIN;
          end
        end else if (hazard_stall) begin
          imem_req = 1'b0;
          state_d  = STALL;
        end else if (imem_ack) begin
          pc_write  = 1'b1;
          ifid_wren = 1'b1;
        end
      end

      STALL: begin
        if (branch_taken) begin
          ifid_flush = 1'b1;
          pc_write   = 1'b1;
          pc_sel     = PC_SEL_TARGET;
          target_c   = pc_branch;
          state_d    = FETCH;
        end else if (!hazard_stall) begin
          state_d = FETCH;
        end
      end

      DRAIN: begin
        imem_req = 1'b1;
        if (branch_taken) begin
          pending_d  = pc_branch;
          ifid_flush = 1'b1;
        end
        if (imem_ack) begin
          // Returned data belongs to the squashed path and is dropped.
          pc_write = 1'b1;
          pc_sel   = PC_SEL_TARGET;
          target_c = branch_taken ? pc_branch : pending_q;
          state_d  = FETCH;
        end
      end
    endcase

    // Outputs are quiet for the whole time reset is held.
    if (reset) begin
      imem_req   = 1'b0;
      pc_write   = 1'b0;
      pc_sel     = PC_SEL_INC;
      target_c   = '0;
      ifid_wren  = 1'b0;
      ifid_flush = 1'b0;
    end
  end

  assign pc_target = (pc_sel == PC_SEL_TARGET) ? target_c : 64'h0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= BOOT;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   ((state_q != BOOT) && !ifid_wren),
    .count (stall_count)
  );

endmodule
